// File: rtl/bram_port_arbiter_if.sv
// Client command/response channels and block RAM port signals for bram_port_arbiter.
// slave = arbiter side, master = clients plus memory instance.
interface bram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16
);
    logic              c0_valid;
    logic              c0_ready;
    logic              c0_we;
    logic [ADDR_W-1:0] c0_addr;
    logic [DATA_W-1:0] c0_wdata;
    logic              c0_rsp_valid;
    logic [DATA_W-1:0] c0_rsp_data;

    logic              c1_valid;
    logic              c1_ready;
    logic              c1_we;
    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c1_wdata;
    logic              c1_rsp_valid;
    logic [DATA_W-1:0] c1_rsp_data;

    logic              mem_wea;
    logic [ADDR_W-1:0] mem_addra;
    logic [DATA_W-1:0] mem_dina;
    logic [ADDR_W-1:0] mem_addrb;
    logic [DATA_W-1:0] mem_doutb;

    modport slave (
        input  c0_valid, c0_we, c0_addr, c0_wdata,
        output c0_ready, c0_rsp_valid, c0_rsp_data,
        input  c1_valid, c1_we, c1_addr, c1_wdata,
        output c1_ready, c1_rsp_valid, c1_rsp_data,
        output mem_wea, mem_addra, mem_dina, mem_addrb,
        input  mem_doutb
    );

    modport master (
        output c0_valid, c0_we, c0_addr, c0_wdata,
        input  c0_ready, c0_rsp_valid, c0_rsp_data,
        output c1_valid, c1_we, c1_addr, c1_wdata,
        input  c1_ready, c1_rsp_valid, c1_rsp_data,
        input  mem_wea, mem_addra, mem_dina, mem_addrb,
        output mem_doutb
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares a simple dual-port block RAM between two clients: round-robin write arbitration on
// port A, round-robin read arbitration on port B, read responses routed back after RD_LAT cycles.
module bram_port_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    bram_port_arbiter_if.slave bus
);
    typedef enum logic {
        CLIENT0 = 1'b0,
        CLIENT1 = 1'b1
    } client_e;

    client_e           wr_prio_q, wr_prio_d;
    client_e           rd_prio_q, rd_prio_d;
    logic [ADDR_W-1:0] addrb_q, addrb_d;
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0] pipe_id_q, pipe_id_d;

    logic              wr_cand0, wr_cand1, rd_cand0, rd_cand1;
    logic              wr_gnt, rd_win, rd_gnt;
    client_e           wr_sel, rd_sel;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        wr_cand0 = !rst && bus.c0_valid && bus.c0_we;
        wr_cand1 = !rst && bus.c1_valid && bus.c1_we;
        rd_cand0 = !rst && bus.c0_valid && !bus.c0_we;
        rd_cand1 = !rst && bus.c1_valid && !bus.c1_we;

        wr_gnt = wr_cand0 || wr_cand1;
        rd_win = rd_cand0 || rd_cand1;
        wr_sel = (wr_cand0 && wr_cand1) ? wr_prio_q : (wr_cand1 ? CLIENT1 : CLIENT0);
        rd_sel = (rd_cand0 && rd_cand1) ? rd_prio_q : (rd_cand1 ? CLIENT1 : CLIENT0);

        wr_addr = (wr_sel == CLIENT1) ? bus.c1_addr  : bus.c0_addr;
        wr_data = (wr_sel == CLIENT1) ? bus.c1_wdata : bus.c0_wdata;
        rd_addr = (rd_sel == CLIENT1) ? bus.c1_addr  : bus.c0_addr;

        // A read colliding with this cycle's write is deferred so it returns the new data.
        rd_gnt = rd_win && !(wr_gnt && (rd_addr == wr_addr));
    end

    always_comb begin
        bus.c0_ready = (wr_gnt && (wr_sel == CLIENT0)) || (rd_gnt && (rd_sel == CLIENT0));
        bus.c1_ready = (wr_gnt && (wr_sel == CLIENT1)) || (rd_gnt && (rd_sel == CLIENT1));

        bus.mem_wea   = wr_gnt;
        bus.mem_addra = wr_gnt ? wr_addr : '0;
        bus.mem_dina  = wr_gnt ? wr_data : '0;
        bus.mem_addrb = rst ? '0 : (rd_gnt ? rd_addr : addrb_q);

        bus.c0_rsp_valid = !rst && pipe_vld_q[RD_LAT-1] && (pipe_id_q[RD_LAT-1] == CLIENT0);
        bus.c1_rsp_valid = !rst && pipe_vld_q[RD_LAT-1] && (pipe_id_q[RD_LAT-1] == CLIENT1);
        bus.c0_rsp_data  = bus.mem_doutb;
        bus.c1_rsp_data  = bus.mem_doutb;
    end

    always_comb begin
        wr_prio_d = wr_gnt ? client_e'(~wr_sel) : wr_prio_q;
        rd_prio_d = rd_gnt ? client_e'(~rd_sel) : rd_prio_q;
        addrb_d   = rd_gnt ? rd_addr : addrb_q;

        pipe_vld_d    = '0;
        pipe_id_d     = '0;
        pipe_vld_d[0] = rd_gnt;
        pipe_id_d[0]  = rd_sel;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_prio_q  <= CLIENT0;
            rd_prio_q  <= CLIENT0;
            addrb_q    <= '0;
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
        end else begin
            wr_prio_q  <= wr_prio_d;
            rd_prio_q  <= rd_prio_d;
            addrb_q    <= addrb_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_id_q  <= pipe_id_d;
        end
    end
endmodule
